// File: rtl/fx_log_lut.sv
// Pipelined fixed-point natural log: x = 2^e * (1+f), ln(x) = e*ln2 + ln(1+f).
// Stages: normalize, ROM read (lo/hi neighbours), interpolate and combine. One global stall enable.
module fx_log_lut #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      QINT        = 16,
  parameter int unsigned      QFRAC       = WIDTH - QINT,
  parameter int unsigned      LUT_BITS    = 10,
  parameter int unsigned      INTERP_BITS = 12,
  parameter logic [WIDTH-1:0] LN2_Q       = 32'h0000B172
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [WIDTH-1:0] x,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] ln_result,
  output logic             err
);

  localparam int unsigned PosW  = $clog2(WIDTH - 1);
  localparam int unsigned ExpW  = $clog2(QINT + QFRAC) + 1;
  localparam int unsigned ManW  = LUT_BITS + INTERP_BITS;
  localparam int unsigned LutN  = 2 ** LUT_BITS;
  localparam int unsigned ProdW = QFRAC + INTERP_BITS;
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

  // ROM entry k = round(ln(1 + k/2^LUT_BITS) * 2^QFRAC), fixed at elaboration.
  logic [QFRAC-1:0] w_rom [LutN + 1];
  for (genvar g = 0; g <= LutN; g++) begin : g_rom
    localparam real LnK  = $ln(1.0 + real'(g) / real'(LutN));
    localparam int  EntK = int'(LnK * real'(2 ** QFRAC));
    assign w_rom[g] = QFRAC'(EntK);
  end

  logic                    w_en;
  logic                    w_nonpos;
  logic [PosW-1:0]         w_pos;
  logic signed [ExpW-1:0]  w_exp;
  logic [WIDTH-2+ManW:0]   w_xpad;
  logic [ManW-1:0]         w_man;
  logic [LUT_BITS:0]       w_i0;
  logic [LUT_BITS:0]       w_i1;
  logic [QFRAC-1:0]        w_diff;
  logic [ProdW-1:0]        w_prod;
  logic [QFRAC-1:0]        w_interp;
  logic [QFRAC-1:0]        w_t;
  logic [WIDTH-1:0]        w_ln;

  logic                    r_v1, r_v2, r_vout;
  logic                    r_err1, r_err2, r_err3;
  logic signed [ExpW-1:0]  r_exp1, r_exp2;
  logic [LUT_BITS-1:0]     r_idx1;
  logic [INTERP_BITS-1:0]  r_fr1, r_fr2;
  logic [QFRAC-1:0]        r_lo2, r_hi2;
  logic [WIDTH-1:0]        r_ln3;

  assign w_en     = ~r_vout | ready_out;
  assign ready_in = w_en;
  assign w_nonpos = x[WIDTH-1] | ~|x;

  always_comb begin
    w_pos = '0;
    for (int k = 0; k < WIDTH - 1; k++) begin
      if (x[k]) w_pos = PosW'(k);
    end
  end

  assign w_exp  = ExpW'(w_pos) - ExpW'(QFRAC);
  // Zero padding below x lets one indexed select pick the ManW bits just under the leading one.
  assign w_xpad = {x[WIDTH-2:0], {ManW{1'b0}}};
  assign w_man  = w_xpad[w_pos +: ManW];

  assign w_i0 = {1'b0, r_idx1};
  assign w_i1 = w_i0 + 1'b1;

  assign w_diff   = r_hi2 - r_lo2;
  assign w_prod   = ProdW'(w_diff) * ProdW'(r_fr2);
  assign w_interp = QFRAC'(w_prod >> INTERP_BITS);
  assign w_t      = r_lo2 + w_interp;
  assign w_ln     = WIDTH'(r_exp2) * LN2_Q + WIDTH'(w_t);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_vout <= 1'b0;
      r_err1 <= 1'b0;
      r_err2 <= 1'b0;
      r_err3 <= 1'b0;
      r_exp1 <= '0;
      r_exp2 <= '0;
      r_idx1 <= '0;
      r_fr1  <= '0;
      r_fr2  <= '0;
      r_lo2  <= '0;
      r_hi2  <= '0;
      r_ln3  <= '0;
    end else if (w_en) begin
      r_v1   <= valid_in;
      r_err1 <= w_nonpos;
      r_exp1 <= w_exp;
      r_idx1 <= w_man[ManW-1 -: LUT_BITS];
      r_fr1  <= w_man[INTERP_BITS-1:0];

      r_v2   <= r_v1;
      r_err2 <= r_err1;
      r_exp2 <= r_exp1;
      r_fr2  <= r_fr1;
      r_lo2  <= w_rom[w_i0];
      r_hi2  <= w_rom[w_i1];

      r_vout <= r_v2;
      // Bubbles leave the last result on the outputs.
      if (r_v2) begin
        r_err3 <= r_err2;
        r_ln3  <= r_err2 ? MinVal : w_ln;
      end
    end
  end

  assign valid_out = r_vout;
  assign ln_result = r_ln3;
  assign err       = r_err3;

endmodule
